// File: rtl/entry_defs.sv
`default_nettype none
// ============================================================================
//  Module      : entry_defs (package)
//  Description : Shared state encodings and BCD limit for the operand-entry
//                stage that feeds the two-digit BCD adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package entry_defs;

    // Entry sequence; the encoding doubles as the LED/debug step value
    localparam logic [2:0] ST_A_TENS = 3'd0;
    localparam logic [2:0] ST_A_ONES = 3'd1;
    localparam logic [2:0] ST_B_TENS = 3'd2;
    localparam logic [2:0] ST_B_ONES = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;

    // Largest legal decimal digit
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // True when the nibble is a legal decimal digit
    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage : entry_defs
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchronises an active-low pushbutton, debounces it and
//                emits a single-cycle pulse on each debounced press.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    // Counter value reached on the last of DEBOUNCE_CYCLES opposite samples
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_raw;

    // Active-high view of the synchronised button
    assign w_raw = ~r_sync1;

    // Two-flop synchroniser; resets to the released (high) level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= key_n;
            r_sync1 <= r_sync0;
        end
    end

    // Stability counter; flips the debounced level after enough opposite samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_level <= w_raw;
                r_cnt   <= '0;
                // Only the released->pressed transition produces a pulse
                r_press <= w_raw;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/bcd_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_operand_entry
//  Description : Four-digit BCD operand entry (A tens, A ones, B tens,
//                B ones) with debounced ENTER/CLEAR keys; drives the
//                adder's a, b and cin from registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_operand_entry
    import entry_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    input  logic [3:0] sw,
    input  logic       sw_cin,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       cin,
    output logic       valid,
    output logic       err,
    output logic [2:0] step
);

    logic       w_enter_press;
    logic       w_clear_press;
    logic       w_enter_level;
    logic       w_clear_level;
    logic       w_unused_levels;

    logic [2:0] r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cin;
    logic       r_valid;
    logic       r_err;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_enter_db (
        .clk   (clk),
        .reset (reset),
        .key_n (key_enter_n),
        .level (w_enter_level),
        .press (w_enter_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_clear_db (
        .clk   (clk),
        .reset (reset),
        .key_n (key_clear_n),
        .level (w_clear_level),
        .press (w_clear_press)
    );

    // Debounced levels are not needed here; only the press pulses drive the FSM
    assign w_unused_levels = w_enter_level ^ w_clear_level;

    // Entry FSM with operand registers; CLEAR takes priority over ENTER
    always_ff @(posedge clk) begin
        if (reset || w_clear_press) begin
            r_state <= ST_A_TENS;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_cin   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_enter_press) begin
            if (r_state == ST_READY) begin
                // Press after a complete entry starts over without capturing
                r_state <= ST_A_TENS;
                r_a     <= 8'h00;
                r_b     <= 8'h00;
                r_cin   <= 1'b0;
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end else if (!is_bcd(sw)) begin
                r_err <= 1'b1;
            end else begin
                r_err <= 1'b0;
                case (r_state)
                    ST_A_TENS: begin
                        r_a[7:4] <= sw;
                        r_state  <= ST_A_ONES;
                    end
                    ST_A_ONES: begin
                        r_a[3:0] <= sw;
                        r_state  <= ST_B_TENS;
                    end
                    ST_B_TENS: begin
                        r_b[7:4] <= sw;
                        r_state  <= ST_B_ONES;
                    end
                    ST_B_ONES: begin
                        r_b[3:0] <= sw;
                        r_cin    <= sw_cin;
                        r_valid  <= 1'b1;
                        r_state  <= ST_READY;
                    end
                    default: begin
                        r_state  <= ST_A_TENS;
                    end
                endcase
            end
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign cin   = r_cin;
    assign valid = r_valid;
    assign err   = r_err;
    assign step  = r_state;

endmodule : bcd_operand_entry
`default_nettype wire

// File: tb/tb_bcd_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_operand_entry
//  Description : Directed self-checking bench for bcd_operand_entry with a
//                short debounce window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_operand_entry;

    localparam int DEB = 4;

    logic       clk;
    logic       reset;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [3:0] sw;
    logic       sw_cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       valid;
    logic       err;
    logic [2:0] step;

    int n_total = 0;
    int n_bad   = 0;

    bcd_operand_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .sw          (sw),
        .sw_cin      (sw_cin),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .valid       (valid),
        .err         (err),
        .step        (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [3:0] d, input logic c);
        sw          = d;
        sw_cin      = c;
        key_enter_n = 1'b0;
        cyc(12);
        key_enter_n = 1'b1;
        cyc(12);
    endtask

    task automatic press_clear();
        key_clear_n = 1'b0;
        cyc(12);
        key_clear_n = 1'b1;
        cyc(12);
    endtask

    task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                             input logic ec, input logic ev, input logic ee, input logic [2:0] es);
        chk({tag, ".a"},     32'(a),     32'(ea));
        chk({tag, ".b"},     32'(b),     32'(eb));
        chk({tag, ".cin"},   32'(cin),   32'(ec));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".err"},   32'(err),   32'(ee));
        chk({tag, ".step"},  32'(step),  32'(es));
    endtask

    initial begin
        reset       = 1'b1;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        sw          = 4'd0;
        sw_cin      = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        check_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // Basic entry 1,2,3,4 with carry-in
        press_enter(4'd1, 1'b0);
        chk("e1.step", 32'(step), 32'd1);
        press_enter(4'd2, 1'b0);
        press_enter(4'd3, 1'b0);
        chk("e3.valid", 32'(valid), 32'd0);
        press_enter(4'd4, 1'b1);
        check_all("e1234", 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 3'd4);

        // ENTER in READY wipes everything without capturing
        press_enter(4'd5, 1'b1);
        check_all("ready_enter", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // Non-BCD digit rejected in A_ONES, then a legal digit accepted
        press_enter(4'd1, 1'b0);
        press_enter(4'hA, 1'b0);
        check_all("nonbcd", 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1);
        press_enter(4'd7, 1'b0);
        check_all("after_err", 8'h17, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2);

        // Bounce on ENTER in B_TENS: no capture while bouncing
        sw = 4'd6;
        for (int i = 0; i < 10; i++) begin
            key_enter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(2);
        end
        chk("bounce.step", 32'(step), 32'd2);
        key_enter_n = 1'b0;
        cyc(4);
        chk("bounce.early", 32'(step), 32'd2);
        cyc(4);
        chk("bounce.capt", 32'(step), 32'd3);
        chk("bounce.b", 32'(b), 32'h60);
        sw = 4'd8;
        cyc(100);
        chk("hold.step", 32'(step), 32'd3);
        chk("hold.b", 32'(b), 32'h60);
        key_enter_n = 1'b1;
        cyc(12);

        // CLEAR in B_TENS with a=99
        press_clear();
        press_enter(4'd9, 1'b0);
        press_enter(4'd9, 1'b0);
        check_all("pre_clear", 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2);
        press_clear();
        check_all("clear_btens", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // Simultaneous CLEAR and ENTER: CLEAR wins
        press_enter(4'd3, 1'b0);
        sw          = 4'd5;
        key_enter_n = 1'b0;
        key_clear_n = 1'b0;
        cyc(12);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        cyc(12);
        check_all("clr_ent", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // Upper boundary 9,9,9,9 with cin=1, then ENTER in READY
        press_enter(4'd9, 1'b0);
        press_enter(4'd9, 1'b0);
        press_enter(4'd9, 1'b0);
        press_enter(4'd9, 1'b1);
        check_all("e9999", 8'h99, 8'h99, 1'b1, 1'b1, 1'b0, 3'd4);
        press_enter(4'd2, 1'b0);
        check_all("ready_clr99", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // Reset mid-debounce discards the pending press
        press_enter(4'd3, 1'b0);
        sw          = 4'd5;
        key_enter_n = 1'b0;
        cyc(4);
        reset = 1'b1;
        cyc(2);
        key_enter_n = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(20);
        check_all("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // Lower boundary 0,0,0,0 with cin=0
        press_enter(4'd0, 1'b0);
        press_enter(4'd0, 1'b0);
        press_enter(4'd0, 1'b0);
        press_enter(4'd0, 1'b0);
        check_all("e0000", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_bcd_operand_entry
`default_nettype wire
